// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared state encodings and widths for the fully-connected feeder
package fc_pkg;

    localparam int IN_DATA_WIDTH_DEFAULT = 16;
    localparam int RESULT_WIDTH          = 4 * IN_DATA_WIDTH_DEFAULT;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fc_state_t;

endpackage

// File: rtl/fc_addr_counter.sv
// rtl/fc_addr_counter.sv - loadable up-counter with a terminal-value flag
module fc_addr_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load clears to zero and wins over a simultaneous enable.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == last_val_i);

endmodule

// File: rtl/fc_core_feeder.sv
// rtl/fc_core_feeder.sv - streams node/weight pairs into one MAC core and latches its result
module fc_core_feeder
    import fc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = IN_DATA_WIDTH_DEFAULT,
    parameter int NUM_INPUT     = 64,
    parameter int ADDR_WIDTH    = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH:0]        i_num_in,
    input  logic [IN_DATA_WIDTH-1:0]   i_bias,
    output logic                       o_idle,
    output logic                       o_done,
    output logic [ADDR_WIDTH-1:0]      o_node_addr,
    output logic                       o_node_ce,
    input  logic [IN_DATA_WIDTH-1:0]   i_node_q,
    output logic [ADDR_WIDTH-1:0]      o_wegt_addr,
    output logic                       o_wegt_ce,
    input  logic [IN_DATA_WIDTH-1:0]   i_wegt_q,
    output logic                       o_core_run,
    output logic                       o_core_valid,
    output logic [IN_DATA_WIDTH-1:0]   o_core_node,
    output logic [IN_DATA_WIDTH-1:0]   o_core_wegt,
    output logic [IN_DATA_WIDTH-1:0]   o_core_bias,
    input  logic                       i_core_valid,
    input  logic [4*IN_DATA_WIDTH-1:0] i_core_result,
    output logic [4*IN_DATA_WIDTH-1:0] o_result,
    output logic                       o_result_valid
);

    localparam int            RES_W = 4 * IN_DATA_WIDTH;
    localparam int            CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_N = CW'(NUM_INPUT);

    fc_state_t              state_q, state_d;
    logic [CW-1:0]          n_q;
    logic [IN_DATA_WIDTH-1:0] bias_q;
    logic                   core_valid_q;
    logic                   core_last_q;
    logic [RES_W-1:0]       result_q;

    logic [CW-1:0]          last_idx;
    logic [CW-1:0]          addr_cnt;
    logic [CW-1:0]          beat_cnt;
    logic                   addr_last;
    logic                   beat_last;
    logic                   cnt_load;
    logic                   fetch_en;
    logic                   beat_en;
    logic                   ce;
    logic                   capture;
    logic                   unused_cnt_bits;

    // N-1 is only meaningful once FETCH is reachable (N >= 1).
    assign last_idx = n_q - CW'(1);

    fc_addr_counter #(.WIDTH(CW)) u_addr_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .en_i       (fetch_en),
        .last_val_i (last_idx),
        .cnt_o      (addr_cnt),
        .last_o     (addr_last)
    );

    fc_addr_counter #(.WIDTH(CW)) u_beat_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .en_i       (beat_en),
        .last_val_i (last_idx),
        .cnt_o      (beat_cnt),
        .last_o     (beat_last)
    );

    assign unused_cnt_bits = ^{addr_cnt[ADDR_WIDTH], beat_cnt};

    // Next-state and per-state control strobes.
    always_comb begin
        state_d  = state_q;
        ce       = 1'b0;
        cnt_load = 1'b0;
        fetch_en = 1'b0;
        beat_en  = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_load = 1'b1;
                state_d  = (n_q == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                ce       = 1'b1;
                fetch_en = ~addr_last;
                beat_en  = i_core_valid;
                if (addr_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                beat_en = i_core_valid;
                if (i_core_valid && beat_last) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample N (clamped) and bias only when a start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q    <= '0;
            bias_q <= '0;
        end else if (state_q == ST_IDLE && i_start) begin
            n_q    <= (i_num_in > MAX_N) ? MAX_N : i_num_in;
            bias_q <= i_bias;
        end
    end

    // Operand valid and last-beat flag trail the BRAM read by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_valid_q <= 1'b0;
            core_last_q  <= 1'b0;
        end else begin
            core_valid_q <= ce;
            core_last_q  <= ce & addr_last;
        end
    end

    // Result latch: the Nth returned beat, or zero for an empty neuron.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
        end else if (capture) begin
            result_q <= i_core_result;
        end else if (state_q == ST_CLR && n_q == '0) begin
            result_q <= '0;
        end
    end

    assign o_idle         = (state_q == ST_IDLE);
    assign o_done         = (state_q == ST_DONE);
    assign o_result_valid = (state_q == ST_DONE);
    assign o_core_run     = (state_q == ST_CLR);
    assign o_node_ce      = ce;
    assign o_wegt_ce      = ce;
    assign o_node_addr    = ce ? addr_cnt[ADDR_WIDTH-1:0] : '0;
    assign o_wegt_addr    = ce ? addr_cnt[ADDR_WIDTH-1:0] : '0;
    assign o_core_valid   = core_valid_q;
    assign o_core_node    = i_node_q;
    assign o_core_wegt    = i_wegt_q;
    // The core adds bias on every beat, so only the final beat carries it.
    assign o_core_bias    = core_last_q ? bias_q : '0;
    assign o_result       = result_q;

endmodule

// File: tb/tb_fc_core_feeder.sv
// tb/tb_fc_core_feeder.sv - directed bench with BRAM and MAC core models
module tb_fc_core_feeder;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [6:0]  i_num_in;
    logic [15:0] i_bias;
    logic        o_idle, o_done, o_node_ce, o_wegt_ce, o_core_run, o_core_valid;
    logic [5:0]  o_node_addr, o_wegt_addr;
    logic [15:0] i_node_q, i_wegt_q, o_core_node, o_core_wegt, o_core_bias;
    logic        i_core_valid;
    logic [63:0] i_core_result, o_result;
    logic        o_result_valid;

    logic [15:0] node_mem [64];
    logic [15:0] wegt_mem [64];

    int checks;
    int errors;

    int run_cnt, run_cyc, ce_cnt, first_ce, last_ce, cv_cnt, done_cnt, done_cyc;
    int bias_cnt, bias_beat, addr_err;
    logic [63:0] res_at_done;
    logic        rv_at_done;

    fc_core_feeder #(.IN_DATA_WIDTH(16), .NUM_INPUT(64), .ADDR_WIDTH(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (i_start),
        .i_num_in       (i_num_in),
        .i_bias         (i_bias),
        .o_idle         (o_idle),
        .o_done         (o_done),
        .o_node_addr    (o_node_addr),
        .o_node_ce      (o_node_ce),
        .i_node_q       (i_node_q),
        .o_wegt_addr    (o_wegt_addr),
        .o_wegt_ce      (o_wegt_ce),
        .i_wegt_q       (i_wegt_q),
        .o_core_run     (o_core_run),
        .o_core_valid   (o_core_valid),
        .o_core_node    (o_core_node),
        .o_core_wegt    (o_core_wegt),
        .o_core_bias    (o_core_bias),
        .i_core_valid   (i_core_valid),
        .i_core_result  (i_core_result),
        .o_result       (o_result),
        .o_result_valid (o_result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] sx(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            i_node_q <= '0;
            i_wegt_q <= '0;
        end else begin
            if (o_node_ce) i_node_q <= node_mem[o_node_addr];
            if (o_wegt_ce) i_wegt_q <= wegt_mem[o_wegt_addr];
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            i_core_result <= '0;
            i_core_valid  <= 1'b0;
        end else if (o_core_run) begin
            i_core_result <= '0;
            i_core_valid  <= 1'b0;
        end else begin
            i_core_valid <= o_core_valid;
            if (o_core_valid)
                i_core_result <= i_core_result + sx(o_core_node) * sx(o_core_wegt) + sx(o_core_bias);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input logic [6:0] n, input logic [15:0] b, input int restart_at, input int max_cyc);
        @(negedge clk);
        i_start  = 1'b1;
        i_num_in = n;
        i_bias   = b;
        run_cnt = 0; run_cyc = -1; ce_cnt = 0; first_ce = -1; last_ce = -1; cv_cnt = 0;
        done_cnt = 0; done_cyc = -1; bias_cnt = 0; bias_beat = -1; addr_err = 0;
        res_at_done = '1; rv_at_done = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            i_start = (c == restart_at);
            if (c == restart_at) begin
                i_num_in = 7'd5;
                i_bias   = 16'd99;
            end
            if (o_core_run) begin run_cnt++; run_cyc = c; end
            if (o_node_ce) begin
                if (first_ce < 0) first_ce = c;
                last_ce = c;
                if (o_node_addr != 6'(ce_cnt) || o_wegt_addr != o_node_addr || !o_wegt_ce) addr_err++;
                ce_cnt++;
            end
            if (o_core_valid) begin
                cv_cnt++;
                if (o_core_bias != '0) begin bias_cnt++; bias_beat = cv_cnt; end
            end
            if (o_done) begin
                done_cnt++; done_cyc = c; res_at_done = o_result; rv_at_done = o_result_valid;
            end
        end
        i_start = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; i_start = 1'b0; i_num_in = '0; i_bias = '0;
        for (int i = 0; i < 64; i++) begin
            node_mem[i] = 16'(i + 1);
            wegt_mem[i] = 16'(i + 5);
        end
        repeat (3) @(negedge clk);
        check("rst_idle",   64'(o_idle), 64'd1);
        check("rst_done",   64'(o_done), 64'd0);
        check("rst_ce",     64'(o_node_ce), 64'd0);
        check("rst_run",    64'(o_core_run), 64'd0);
        check("rst_valid",  64'(o_core_valid), 64'd0);
        check("rst_result", o_result, 64'd0);
        check("rst_addr",   64'(o_node_addr), 64'd0);
        reset = 1'b0;

        do_run(7'd4, 16'd10, -1, 11);
        check("n4_result",   res_at_done, 64'd80);
        check("n4_done_cyc", 64'(done_cyc), 64'd8);
        check("n4_done_cnt", 64'(done_cnt), 64'd1);
        check("n4_rvalid",   64'(rv_at_done), 64'd1);
        check("n4_run_cyc",  64'(run_cyc), 64'd1);
        check("n4_ce_cnt",   64'(ce_cnt), 64'd4);
        check("n4_first_ce", 64'(first_ce), 64'd2);
        check("n4_last_ce",  64'(last_ce), 64'd5);
        check("n4_cv_cnt",   64'(cv_cnt), 64'd4);
        check("n4_bias_cnt", 64'(bias_cnt), 64'd1);
        check("n4_bias_beat", 64'(bias_beat), 64'd4);
        check("n4_addr",     64'(addr_err), 64'd0);
        check("n4_hold",     o_result, 64'd80);

        do_run(7'd0, 16'd7, -1, 5);
        check("n0_run_cyc",  64'(run_cyc), 64'd1);
        check("n0_ce_cnt",   64'(ce_cnt), 64'd0);
        check("n0_cv_cnt",   64'(cv_cnt), 64'd0);
        check("n0_done_cyc", 64'(done_cyc), 64'd2);
        check("n0_result",   res_at_done, 64'd0);

        do_run(7'd3, 16'd10, 3, 12);
        check("n3_done_cnt", 64'(done_cnt), 64'd1);
        check("n3_done_cyc", 64'(done_cyc), 64'd7);
        check("n3_result",   res_at_done, 64'd48);
        check("n3_run_cnt",  64'(run_cnt), 64'd1);
        check("n3_ce_cnt",   64'(ce_cnt), 64'd3);
        check("n3_idle",     64'(o_idle), 64'd1);

        @(negedge clk);
        i_start = 1'b1; i_num_in = 7'd8; i_bias = 16'd5;
        @(negedge clk); i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("rstmid_idle",   64'(o_idle), 64'd1);
        check("rstmid_ce",     64'(o_node_ce), 64'd0);
        check("rstmid_valid",  64'(o_core_valid), 64'd0);
        check("rstmid_node",   64'(o_core_node), 64'd0);
        check("rstmid_bias",   64'(o_core_bias), 64'd0);
        check("rstmid_result", o_result, 64'd0);
        check("rstmid_done",   64'(o_done), 64'd0);
        reset = 1'b0;
        done_cnt = 0;
        repeat (12) @(negedge clk) if (o_done) done_cnt++;
        check("rstmid_no_done", 64'(done_cnt), 64'd0);

        do_run(7'd2, 16'd3, -1, 8);
        check("n2_result",   res_at_done, 64'd20);
        check("n2_done_cyc", 64'(done_cyc), 64'd6);

        do_run(7'd100, 16'd1, -1, 70);
        check("clamp_ce_cnt",   64'(ce_cnt), 64'd64);
        check("clamp_last_ce",  64'(last_ce), 64'd65);
        check("clamp_done_cyc", 64'(done_cyc), 64'd68);
        check("clamp_result",   res_at_done, 64'd97761);
        check("clamp_addr",     64'(addr_err), 64'd0);

        node_mem[0] = 16'hFFFD;
        wegt_mem[0] = 16'd4;
        do_run(7'd1, 16'hFFFE, -1, 7);
        check("signed_result",   res_at_done, 64'hFFFF_FFFF_FFFF_FFF2);
        check("signed_done_cyc", 64'(done_cyc), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
